// File: rtl/jk_excite_counter_if.sv
// rtl/jk_excite_counter_if.sv - control and JK bank signal bundle for jk_excite_counter
//
// Purpose: groups the control inputs, the JK excitation to the external bank,
// the bank Q feedback and the status outputs of jk_excite_counter.
// Signals:
//   en, clr, mode, load_val : control from the driving logic
//   q_ext                   : Q fed back from the external ff_jk bank
//   q, j, k                 : shadow count and excitation for the next edge
//   tc, armed, err          : wrap pulse, checking-active, sticky mismatch
// Modports: master = control/bank side, slave = the counter.
interface jk_excite_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_ext;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             tc;
  logic             armed;
  logic             err;

  modport master (
    output en, clr, mode, load_val, q_ext,
    input  q, j, k, tc, armed, err
  );

  modport slave (
    input  en, clr, mode, load_val, q_ext,
    output q, j, k, tc, armed, err
  );
endinterface

// File: rtl/jk_excite_counter.sv
// rtl/jk_excite_counter.sv - modulo-(MAX+1) up/down/load counter producing JK excitation
//
// Purpose: keeps a shadow count, drives J/K for an external reset-less ff_jk
// bank so that the bank follows the count, and checks the bank's Q against
// the shadow once the bank has been forced to a known value.
// Ports:
//   clk   : clock, posedge active
//   res_n : asynchronous active-low reset
//   bus   : jk_excite_counter_if slave (en, clr, mode, load_val, q_ext in;
//           q, j, k, tc, armed, err out)
module jk_excite_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic                 clk,
  input  logic                 res_n,
  jk_excite_counter_if.slave   bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             armed_q, armed_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] n_c;
  logic [WIDTH-1:0] j_c, k_c;
  logic             forcing_c;
  logic             wrap_c;

  always_comb begin
    n_c       = q_q;
    wrap_c    = 1'b0;
    forcing_c = bus.clr | (bus.en & (bus.mode == MODE_LOAD));

    if (bus.clr) begin
      n_c = '0;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_UP: begin
          wrap_c = (q_q == MAX_V);
          n_c    = wrap_c ? '0 : q_q + ONE;
        end
        MODE_DOWN: begin
          wrap_c = (q_q == '0);
          n_c    = wrap_c ? MAX_V : q_q - ONE;
        end
        MODE_LOAD: n_c = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        default:   n_c = q_q;
      endcase
    end

    // Forcing drives set/reset on every bit so the bank lands on N whatever
    // it held before; otherwise only changing bits are excited, which never
    // produces j=k=1.
    if (forcing_c) begin
      j_c = n_c;
      k_c = ~n_c;
    end else begin
      j_c = n_c & ~q_q;
      k_c = ~n_c & q_q;
    end

    // Shadow follows the same JK rule the bank applies.
    q_d     = (j_c & ~q_q) | (~k_c & q_q);
    tc_d    = wrap_c;
    armed_d = armed_q | forcing_c;

    err_d = err_q;
    if (bus.clr) begin
      err_d = 1'b0;
    end else if (armed_q && (bus.q_ext != q_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q_q     <= '0;
      tc_q    <= 1'b0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      tc_q    <= tc_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.j     = j_c;
  assign bus.k     = k_c;
  assign bus.tc    = tc_q;
  assign bus.armed = armed_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_jk_excite_counter.sv
// tb/tb_jk_excite_counter.sv - directed self-checking bench for jk_excite_counter
module tb_jk_excite_counter;
  logic clk;
  logic res_n;
  int   tests;
  int   failed;

  logic [3:0] bank;
  logic [3:0] flip;

  jk_excite_counter_if #(.WIDTH(4)) bus ();
  jk_excite_counter_if #(.WIDTH(4)) bus1 ();

  jk_excite_counter #(.WIDTH(4), .MAX(9)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  jk_excite_counter #(.WIDTH(4), .MAX(1)) dut1 (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset-less external ff_jk bank driven by the DUT's excitation.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      case ({bus.j[b], bus.k[b]})
        2'b10:   bank[b] <= 1'b1;
        2'b01:   bank[b] <= 1'b0;
        2'b11:   bank[b] <= ~bank[b];
        default: bank[b] <= bank[b];
      endcase
    end
  end

  assign bus.q_ext  = bank ^ flip;
  assign bus1.q_ext = 4'd0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    flip         = 4'd0;
    res_n        = 1'b0;
    bus.en       = 1'b0;
    bus.clr      = 1'b0;
    bus.mode     = 2'b00;
    bus.load_val = 4'd0;
    bus1.en       = 1'b1;
    bus1.clr      = 1'b0;
    bus1.mode     = 2'b01;
    bus1.load_val = 4'd0;

    // Reset state
    #2;
    check("rst_q",     16'(bus.q),     16'h0);
    check("rst_tc",    16'(bus.tc),    16'h0);
    check("rst_armed", 16'(bus.armed), 16'h0);
    check("rst_err",   16'(bus.err),   16'h0);
    step();
    step();
    res_n = 1'b1;

    // 1. clr forces the unknown bank to 0
    bus.clr = 1'b1;
    #1;
    check("t1_j", 16'(bus.j), 16'h0);
    check("t1_k", 16'(bus.k), 16'hF);
    step();
    bus.clr = 1'b0;
    check("t1_q",     16'(bus.q),     16'h0);
    check("t1_armed", 16'(bus.armed), 16'h1);
    check("t1_err",   16'(bus.err),   16'h0);

    // 2. count up 12 edges with MAX=9
    bus.en   = 1'b1;
    bus.mode = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      #1;
      if (i == 8) begin
        check("t2_j_7to8", 16'(bus.j), 16'h8);
        check("t2_k_7to8", 16'(bus.k), 16'h7);
      end
      step();
      check($sformatf("t2_q%0d", i),  16'(bus.q),  16'(i % 10));
      check($sformatf("t2_tc%0d", i), 16'(bus.tc), (i == 10) ? 16'h1 : 16'h0);
    end
    check("t2_err", 16'(bus.err), 16'h0);

    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check("t2_clr_q",  16'(bus.q),  16'h0);
    check("t2_clr_tc", 16'(bus.tc), 16'h0);

    // 3. count down from 0 wraps to 9
    bus.mode = 2'b10;
    step();
    check("t3_q9",  16'(bus.q),  16'h9);
    check("t3_tc9", 16'(bus.tc), 16'h1);
    #1;
    check("t3_j", 16'(bus.j), 16'h0);
    check("t3_k", 16'(bus.k), 16'h1);
    step();
    check("t3_q8",  16'(bus.q),  16'h8);
    check("t3_tc8", 16'(bus.tc), 16'h0);

    // 4. saturating load, then load with en=0 ignored, then hold at MAX
    bus.mode     = 2'b11;
    bus.load_val = 4'd13;
    #1;
    check("t4_j", 16'(bus.j), 16'h9);
    check("t4_k", 16'(bus.k), 16'h6);
    step();
    check("t4_q",  16'(bus.q),  16'h9);
    check("t4_tc", 16'(bus.tc), 16'h0);
    bus.en       = 1'b0;
    bus.load_val = 4'd5;
    #1;
    check("t4_noload_j", 16'(bus.j), 16'h0);
    check("t4_noload_k", 16'(bus.k), 16'h0);
    step();
    check("t4_noload_q", 16'(bus.q), 16'h9);
    bus.en   = 1'b1;
    bus.mode = 2'b00;
    step();
    check("t4_hold_q",  16'(bus.q),  16'h9);
    check("t4_hold_tc", 16'(bus.tc), 16'h0);
    check("t4_err",     16'(bus.err), 16'h0);

    // 5. mismatch sets sticky err; clr clears it even with mismatch present
    bus.mode = 2'b01;
    step();
    check("t5_q0",  16'(bus.q),  16'h0);
    check("t5_tc0", 16'(bus.tc), 16'h1);
    flip = 4'b0001;
    step();
    flip = 4'b0000;
    check("t5_err_set", 16'(bus.err), 16'h1);
    check("t5_q1",      16'(bus.q),   16'h1);
    step();
    step();
    check("t5_err_sticky", 16'(bus.err), 16'h1);
    check("t5_q3",         16'(bus.q),   16'h3);
    flip    = 4'b0001;
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    flip    = 4'b0000;
    check("t5_clr_err", 16'(bus.err), 16'h0);
    check("t5_clr_q",   16'(bus.q),   16'h0);

    // 6. asynchronous reset mid-count, no compare until re-armed
    for (int i = 0; i < 6; i++) step();
    check("t6_q6", 16'(bus.q), 16'h6);
    #2;
    res_n = 1'b0;
    #1;
    check("t6_rst_q",     16'(bus.q),     16'h0);
    check("t6_rst_tc",    16'(bus.tc),    16'h0);
    check("t6_rst_armed", 16'(bus.armed), 16'h0);
    #1;
    res_n = 1'b1;
    flip  = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("t6_err%0d", i),   16'(bus.err),   16'h0);
      check($sformatf("t6_armed%0d", i), 16'(bus.armed), 16'h0);
      check($sformatf("t6_q%0d", i),     16'(bus.q),     16'(i));
      // MAX=1 counter counting up alongside: tc every second cycle
      check($sformatf("max1_q%0d", i),  16'(bus1.q),  16'(i % 2));
      check($sformatf("max1_tc%0d", i), 16'(bus1.tc), (i % 2 == 0) ? 16'h1 : 16'h0);
    end
    flip    = 4'b0000;
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check("t6_rearm_armed", 16'(bus.armed), 16'h1);
    check("t6_rearm_q",     16'(bus.q),     16'h0);
    check("t6_rearm_err",   16'(bus.err),   16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
